latency_timer_mc: RTL

LATENCY_TIMER_MC -- requirements
Module: latency_timer_mc

---
 rtl/latency_timer_mc_if.sv | 29 ++
 rtl/latency_timer_mc.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/latency_timer_mc_if.sv
// rtl/latency_timer_mc_if.sv - event, control and readout bundle of the multi-channel latency timer
interface latency_timer_mc_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 20
);
  logic              enable;
  logic              clear_stats;
  logic [NUM_CH-1:0] frame_sent;
  logic [NUM_CH-1:0] frame_caught;
  logic [2:0]        ch_sel;
  logic [NUM_CH-1:0] meas_done;
  logic [NUM_CH-1:0] busy;
  logic [CNT_W-1:0]  rd_last;
  logic [CNT_W-1:0]  rd_min;
  logic [CNT_W-1:0]  rd_max;
  logic [15:0]       rd_count;
  logic [15:0]       rd_lost;
  logic [CNT_W+15:0] rd_sum;

  modport master (
    output enable, clear_stats, frame_sent, frame_caught, ch_sel,
    input  meas_done, busy, rd_last, rd_min, rd_max, rd_count, rd_lost, rd_sum
  );

  modport slave (
    input  enable, clear_stats, frame_sent, frame_caught, ch_sel,
    output meas_done, busy, rd_last, rd_min, rd_max, rd_count, rd_lost, rd_sum
  );
endinterface

// File: rtl/latency_timer_mc.sv
// rtl/latency_timer_mc.sv - per-channel frame latency measurement with min/max/sum/count/lost statistics
module latency_timer_mc #(
  parameter int               NUM_CH  = 2,
  parameter int               CNT_W   = 20,
  parameter logic [CNT_W-1:0] TIMEOUT = '1
) (
  input logic               tx_clk,
  input logic               reset_n,
  latency_timer_mc_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q [NUM_CH];
  state_t            state_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d   [NUM_CH];
  logic [NUM_CH-1:0] rec;
  logic [NUM_CH-1:0] tmo;

  logic [CNT_W-1:0]  last_q  [NUM_CH];
  logic [CNT_W-1:0]  min_q   [NUM_CH];
  logic [CNT_W-1:0]  max_q   [NUM_CH];
  logic [15:0]       count_q [NUM_CH];
  logic [15:0]       lost_q  [NUM_CH];
  logic [CNT_W+15:0] sum_q   [NUM_CH];

  logic [CNT_W-1:0]  sel_last, sel_min, sel_max;
  logic [15:0]       sel_count, sel_lost;
  logic [CNT_W+15:0] sel_sum;

  always_ff @(posedge tx_clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (!reset_n) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end else begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // A catch always wins over the timeout; a catch plus a new start restarts in place.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      rec[i]     = 1'b0;
      tmo[i]     = 1'b0;
      case (state_q[i])
        IDLE: begin
          if (bus.frame_sent[i] && bus.enable) begin
            state_d[i] = RUN;
            cnt_d[i]   = CNT_W'(1);
          end
        end
        RUN: begin
          cnt_d[i] = (cnt_q[i] == '1) ? cnt_q[i] : cnt_q[i] + 1'b1;
          if (bus.frame_caught[i]) begin
            rec[i] = 1'b1;
            if (bus.frame_sent[i] && bus.enable) cnt_d[i] = CNT_W'(1);
            else                                 state_d[i] = IDLE;
          end else if (cnt_q[i] == TIMEOUT) begin
            tmo[i]     = 1'b1;
            state_d[i] = IDLE;
          end
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) bus.busy[i] = (state_q[i] == RUN);
  end

  // Statistics; a clear in the same cycle as a record or timeout discards that event.
  always_ff @(posedge tx_clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (!reset_n || bus.clear_stats) begin
        last_q[i]  <= '0;
        min_q[i]   <= '1;
        max_q[i]   <= '0;
        count_q[i] <= '0;
        lost_q[i]  <= '0;
        sum_q[i]   <= '0;
      end else begin
        if (rec[i]) begin
          last_q[i]  <= cnt_q[i];
          min_q[i]   <= (cnt_q[i] < min_q[i]) ? cnt_q[i] : min_q[i];
          max_q[i]   <= (cnt_q[i] > max_q[i]) ? cnt_q[i] : max_q[i];
          count_q[i] <= (count_q[i] == 16'hFFFF) ? count_q[i] : count_q[i] + 16'd1;
          sum_q[i]   <= sum_q[i] + {16'd0, cnt_q[i]};
        end
        if (tmo[i]) lost_q[i] <= (lost_q[i] == 16'hFFFF) ? lost_q[i] : lost_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge tx_clk) begin
    if (!reset_n) bus.meas_done <= '0;
    else          bus.meas_done <= rec;
  end

  always_comb begin
    sel_last  = '0;
    sel_min   = '0;
    sel_max   = '0;
    sel_count = '0;
    sel_lost  = '0;
    sel_sum   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.ch_sel == 3'(i)) begin
        sel_last  = last_q[i];
        sel_min   = min_q[i];
        sel_max   = max_q[i];
        sel_count = count_q[i];
        sel_lost  = lost_q[i];
        sel_sum   = sum_q[i];
      end
    end
  end

  always_ff @(posedge tx_clk) begin
    if (!reset_n) begin
      bus.rd_last  <= '0;
      bus.rd_min   <= '0;
      bus.rd_max   <= '0;
      bus.rd_count <= '0;
      bus.rd_lost  <= '0;
      bus.rd_sum   <= '0;
    end else begin
      bus.rd_last  <= sel_last;
      bus.rd_min   <= sel_min;
      bus.rd_max   <= sel_max;
      bus.rd_count <= sel_count;
      bus.rd_lost  <= sel_lost;
      bus.rd_sum   <= sel_sum;
    end
  end
endmodule
